mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Initiator side of the data-memory interface: the MEM stage hands a load/store request to this block, which drives the `memory` module's `ce`/`we`/`addr`/`byte_slct`/`data` inputs. It handles sub-word byte-lane steering and load sign/zero extension. It also detects misaligned addresses and stalls the pipeline for the access latency. It sits between the MEM pipeline stage and the data `memory` instance.

## Interface
- `AddrWidth`, 32, byte-address width.
- `DataWidth`, 32, memory word width (fixed at 32 for lane logic).
- `WaitCycles`, 1, cycles `mem_ce_o` is held before read data is sampled (≥1).

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  access request; held with `op_i`/`addr_i`/`wdata_i` stable until `done_o`.
- `op_i`  in  4  MemOp code: LB, LBU, LH, LHU, LW, SB, SH, SW.
- `addr_i`  in  AddrWidth  byte address.
- `wdata_i`  in  32  store data, right-justified.
- `stall_o`  out  1  pipeline hold.
- `done_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  32  extended load result.
- `addr_err_o`  out  1  one-cycle misalignment pulse, coincident with `done_o`.
- `mem_ce_o`  out  1  memory chip enable.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  AddrWidth  word-aligned address (`addr_i & ~3`).
- `mem_byte_slct_o`  out  4  byte lanes. Bit k enables data bits [8k+7:8k].
- `mem_data_o`  out  32  lane-replicated store data.
- `mem_data_i`  in  32  memory read data.

## Operation
- Byte order is big-endian. Offset `a = addr_i[1:0]` maps to lane `3-a`. A halfword at offset 0 uses lanes 3,2; at offset 2 it uses lanes 1,0.
- Store data is replicated across lanes: SB → `{4{wdata_i[7:0]}}`, SH → `{2{wdata_i[15:0]}}`, SW → `wdata_i`.
- `mem_byte_slct_o` patterns:
  - Byte: one-hot lane.
  - Halfword: `1100` or `0011`.
  - Word: `1111`.
  - Loads use the same pattern.
- Load extension:
  - LB/LH sign-extend the selected lane(s).
  - LBU/LHU zero-extend.
  - LW passes the word.
- Misaligned: halfword with `a[0]=1`, or word with `a≠0`. No memory access occurs; `addr_err_o` and `done_o` pulse; `rdata_o` is unchanged.
- FSM states:
  - IDLE: on `req_i` → ACCESS if aligned, else ERR.
  - ACCESS: held `WaitCycles` cycles via a down-counter. `mem_ce_o=1`, and `mem_we_o=1` for stores only. On the last edge, capture `mem_data_i` (loads) and go → DONE.
  - DONE: `done_o=1`; `rdata_o` updated (loads only); → IDLE.
  - ERR: `done_o=1`, `addr_err_o=1`; → IDLE.
- `stall_o = (state==IDLE && req_i) || state==ACCESS`. It is low in DONE and ERR.
- If `req_i` drops mid-ACCESS, the access still completes. Writes are never truncated.
- Unknown `op_i` is treated as a no-op and completes via DONE with no memory access.

## Timing
- Reset (any time, including mid-ACCESS): state IDLE; every output is 0, including `rdata_o`; the counter is cleared.
- All `mem_*` outputs and `done_o`/`addr_err_o`/`rdata_o` are registered.
- Request sampled at edge E0:
  - ACCESS covers the cycles after edges E0 … E0+W-1.
  - Data is captured at E0+W.
  - `done_o` is high for the cycle after E0+W.
  - IDLE is reached after E0+W+1.
- With `WaitCycles=1`, `done_o` comes 2 edges after acceptance.
- Misaligned: `done_o`/`addr_err_o` are high for the cycle after E0; there is no `mem_ce_o`.
- Back-to-back requests get one bubble (the DONE/ERR cycle). The next request is accepted at the edge leaving DONE only if `req_i` is seen in IDLE, i.e. at the following edge.
- `mem_ce_o`/`mem_we_o` are 0 outside ACCESS. `mem_addr_o`/`mem_data_o`/`mem_byte_slct_o` hold their last values.

## Structure
- Add the MemOp codes, the `ByteSlctWidth` reuse and the state encodings as macros in `define.v`.
- One combinational sub-module, `mem_lane_align`, computes the byte-select pattern, store replication, misalignment flag and load extension. The FSM stays in `mem_access_ctrl`.

## Test plan
- SW `addr=0x8`, `wdata=0xDEADBEEF`, W=1 → one ACCESS cycle with `ce=1`, `we=1`, `byte_slct=1111`, `mem_addr=0x8`. `done_o` is 2 edges after acceptance; `stall_o` is high until then.
- Preload word `0x80FF7F01` at 0x4:
  - LB 0x4 → `0xFFFFFF80`
  - LBU 0x5 → `0x000000FF`
  - LH 0x6 → `0x00007F01`
  - LHU 0x4 → `0x000080FF`
- SH `addr=0x2`, `wdata=0x1234ABCD` → `byte_slct=0011`, `mem_data=0xABCDABCD`. Readback LW gives the upper half unchanged and the lower half `0xABCD`.
- LW `addr=0x6` → `addr_err_o` and `done_o` for one cycle; `mem_ce_o` never rises; `rdata_o` is unchanged.
- `WaitCycles=3` SB, with `rst` asserted during the 2nd ACCESS cycle → all outputs 0 immediately and IDLE. A subsequent LW completes normally after 4 edges.
- `req_i` dropped mid-ACCESS on SW → the write still completes and `done_o` still pulses.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared op codes, FSM states and access-size helper
// for the data-memory initiator.
package mem_access_ctrl_pkg;

    localparam int ByteSlctWidth = 4;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LB  = 4'd1,
        OP_LBU = 4'd2,
        OP_LH  = 4'd3,
        OP_LHU = 4'd4,
        OP_LW  = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_ERR
    } state_e;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    function automatic size_e op_size(input logic [3:0] op);
        return (op == OP_LB || op == OP_LBU || op == OP_SB) ? SZ_BYTE :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? SZ_HALF :
               (op == OP_LW || op == OP_SW)                 ? SZ_WORD : SZ_NONE;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian byte-lane steering, store replication,
// misalignment detection and load sign/zero extension (purely combinational).
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [3:0]               op_i,
    input  logic [1:0]               off_i,
    input  logic [31:0]              wdata_i,
    input  logic [31:0]              rdata_i,
    output logic [ByteSlctWidth-1:0] byte_slct_o,
    output logic [31:0]              wdata_o,
    output logic [31:0]              rdata_o,
    output logic                     misaligned_o,
    output logic                     load_o,
    output logic                     store_o
);

    size_e       size;
    logic        sext;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        size         = op_size(op_i);
        load_o       = op_i inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
        store_o      = op_i inside {OP_SB, OP_SH, OP_SW};
        sext         = op_i inside {OP_LB, OP_LH};
        // offset a lives in lane 3-a, i.e. bit base 8*(~a)
        rbyte        = rdata_i[{~off_i, 3'b000} +: 8];
        rhalf        = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        misaligned_o = (size == SZ_HALF && off_i[0]) || (size == SZ_WORD && off_i != 2'b00);
        byte_slct_o  = size == SZ_BYTE ? 4'b1000 >> off_i :
                       size == SZ_HALF ? (off_i[1] ? 4'b0011 : 4'b1100) :
                       size == SZ_WORD ? 4'b1111 : 4'b0000;
        wdata_o      = size == SZ_BYTE ? {4{wdata_i[7:0]}} :
                       size == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o      = size == SZ_BYTE ? {{24{sext & rbyte[7]}}, rbyte} :
                       size == SZ_HALF ? {{16{sext & rhalf[15]}}, rhalf} :
                       size == SZ_WORD ? rdata_i : 32'h0;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage initiator for the data memory; sequences one
// load/store at a time through IDLE/ACCESS/DONE/ERR with registered outputs.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = 32,
    parameter int WaitCycles = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_i,
    input  logic [3:0]               op_i,
    input  logic [AddrWidth-1:0]     addr_i,
    input  logic [DataWidth-1:0]     wdata_i,
    output logic                     stall_o,
    output logic                     done_o,
    output logic [DataWidth-1:0]     rdata_o,
    output logic                     addr_err_o,
    output logic                     mem_ce_o,
    output logic                     mem_we_o,
    output logic [AddrWidth-1:0]     mem_addr_o,
    output logic [ByteSlctWidth-1:0] mem_byte_slct_o,
    output logic [DataWidth-1:0]     mem_data_o,
    input  logic [DataWidth-1:0]     mem_data_i
);

    localparam int CntW = WaitCycles > 1 ? $clog2(WaitCycles) : 1;

    state_e                   state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [3:0]               op_q, op_d;
    logic [1:0]               off_q, off_d;
    logic                     ce_q, ce_d, we_q, we_d, done_q, done_d, err_q, err_d;
    logic [AddrWidth-1:0]     addr_q, addr_d;
    logic [ByteSlctWidth-1:0] sel_q, sel_d;
    logic [DataWidth-1:0]     mdata_q, mdata_d, rdata_q, rdata_d;

    logic                     in_access;
    logic [ByteSlctWidth-1:0] lane_sel;
    logic [31:0]              lane_wdata, lane_rdata;
    logic                     misaligned, is_load, is_store;

    assign in_access = state_q == S_ACCESS;

    // The request may be withdrawn mid-access, so decode from the latched op then.
    mem_lane_align u_align (
        .op_i         (in_access ? op_q : op_i),
        .off_i        (in_access ? off_q : addr_i[1:0]),
        .wdata_i      (wdata_i),
        .rdata_i      (mem_data_i),
        .byte_slct_o  (lane_sel),
        .wdata_o      (lane_wdata),
        .rdata_o      (lane_rdata),
        .misaligned_o (misaligned),
        .load_o       (is_load),
        .store_o      (is_store)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        off_d   = off_q;
        ce_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        sel_d   = sel_q;
        mdata_d = mdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    op_d  = op_i;
                    off_d = addr_i[1:0];
                    if (misaligned) begin
                        state_d = S_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (!is_load && !is_store) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = CntW'(WaitCycles - 1);
                        ce_d    = 1'b1;
                        we_d    = is_store;
                        addr_d  = {addr_i[AddrWidth-1:2], 2'b00};
                        sel_d   = lane_sel;
                        mdata_d = lane_wdata;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    rdata_d = is_load ? lane_rdata : rdata_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    ce_d  = 1'b1;
                    we_d  = we_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            off_q   <= '0;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            mdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            off_q   <= off_d;
            ce_q    <= ce_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            mdata_q <= mdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign stall_o         = (state_q == S_IDLE && req_i) || in_access;
    assign done_o          = done_q;
    assign addr_err_o      = err_q;
    assign rdata_o         = rdata_q;
    assign mem_ce_o        = ce_q;
    assign mem_we_o        = we_q;
    assign mem_addr_o      = addr_q;
    assign mem_byte_slct_o = sel_q;
    assign mem_data_o      = mdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench for mem_access_ctrl with WaitCycles=1 and
// WaitCycles=3 instances, each backed by a small byte-lane memory model.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst1, rst3;
    logic        req1, req3;
    logic [3:0]  op1, op3;
    logic [31:0] addr1, addr3, wdata1, wdata3;
    logic        stall1, stall3, done1, done3, err1, err3;
    logic        ce1, ce3, we1, we3;
    logic [31:0] rdata1, rdata3, maddr1, maddr3, mdata1, mdata3, mrd1, mrd3;
    logic [3:0]  sel1, sel3;
    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.AddrWidth(32), .DataWidth(32), .WaitCycles(1)) u_dut1 (
        .clk(clk), .rst(rst1), .req_i(req1), .op_i(op1), .addr_i(addr1), .wdata_i(wdata1),
        .stall_o(stall1), .done_o(done1), .rdata_o(rdata1), .addr_err_o(err1),
        .mem_ce_o(ce1), .mem_we_o(we1), .mem_addr_o(maddr1), .mem_byte_slct_o(sel1),
        .mem_data_o(mdata1), .mem_data_i(mrd1)
    );

    mem_access_ctrl #(.AddrWidth(32), .DataWidth(32), .WaitCycles(3)) u_dut3 (
        .clk(clk), .rst(rst3), .req_i(req3), .op_i(op3), .addr_i(addr3), .wdata_i(wdata3),
        .stall_o(stall3), .done_o(done3), .rdata_o(rdata3), .addr_err_o(err3),
        .mem_ce_o(ce3), .mem_we_o(we3), .mem_addr_o(maddr3), .mem_byte_slct_o(sel3),
        .mem_data_o(mdata3), .mem_data_i(mrd3)
    );

    assign mrd1 = mem1[maddr1[5:2]];
    assign mrd3 = mem3[maddr3[5:2]];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ce1 && we1 && sel1[k]) mem1[maddr1[5:2]][8*k +: 8] <= mdata1[8*k +: 8];
            if (ce3 && we3 && sel3[k]) mem3[maddr3[5:2]][8*k +: 8] <= mdata3[8*k +: 8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input bit u3, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, output int edges, output logic saw_ce,
                       output logic err);
        if (u3) begin
            req3 = 1'b1; op3 = op; addr3 = addr; wdata3 = wd;
        end else begin
            req1 = 1'b1; op1 = op; addr1 = addr; wdata1 = wd;
        end
        edges  = -1;
        saw_ce = 1'b0;
        err    = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            saw_ce = saw_ce | (u3 ? ce3 : ce1);
            if (u3 ? done3 : done1) begin
                edges = i;
                err   = u3 ? err3 : err1;
                break;
            end
        end
        req1 = 1'b0;
        req3 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst1 = 1'b0; rst3 = 1'b0;
        req1 = 1'b0; op1 = '0; addr1 = '0; wdata1 = '0;
        req3 = 1'b0; op3 = '0; addr3 = '0; wdata3 = '0;
        tick(); tick();
        tests_run++; if ({stall1, done1, err1, ce1, we1, sel1} !== 9'h0) begin tests_failed++; $display("FAIL reset_ctl1 got %h exp 0", {stall1, done1, err1, ce1, we1, sel1}); end
        tests_run++; if ({rdata1, maddr1, mdata1} !== 96'h0) begin tests_failed++; $display("FAIL reset_data1 got %h exp 0", {rdata1, maddr1, mdata1}); end
        tests_run++; if ({stall3, done3, err3, ce3, we3, sel3, rdata3, maddr3, mdata3} !== 105'h0) begin tests_failed++; $display("FAIL reset_all3 got %h exp 0", {stall3, done3, err3, ce3, we3, sel3, rdata3, maddr3, mdata3}); end
        rst1 = 1'b1; rst3 = 1'b1;
        tick();
    endtask

    task automatic test_store_word();
        req1 = 1'b1; op1 = OP_SW; addr1 = 32'h8; wdata1 = 32'hDEADBEEF;
        #1;
        tests_run++; if (stall1 !== 1'b1) begin tests_failed++; $display("FAIL sw_stall_idle got %b exp 1", stall1); end
        tick();
        tests_run++; if ({ce1, we1, sel1, stall1, done1} !== 8'b11_1111_10) begin tests_failed++; $display("FAIL sw_access_ctl got %b exp 11111110", {ce1, we1, sel1, stall1, done1}); end
        tests_run++; if ({maddr1, mdata1} !== {32'h8, 32'hDEADBEEF}) begin tests_failed++; $display("FAIL sw_access_data got %h exp 00000008deadbeef", {maddr1, mdata1}); end
        tick();
        tests_run++; if ({done1, stall1, ce1, we1, err1} !== 5'b10000) begin tests_failed++; $display("FAIL sw_done got %b exp 10000", {done1, stall1, ce1, we1, err1}); end
        req1 = 1'b0;
        tick();
        tests_run++; if (done1 !== 1'b0) begin tests_failed++; $display("FAIL sw_done_pulse got %b exp 0", done1); end
        tests_run++; if (mem1[2] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL sw_mem got %h exp deadbeef", mem1[2]); end
    endtask

    task automatic test_loads();
        logic [3:0]  ops  [5] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
        logic [31:0] adrs [5] = '{32'h4, 32'h5, 32'h6, 32'h4, 32'h4};
        logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h000000FF, 32'h00007F01, 32'h000080FF, 32'h80FF7F01};
        int   edges;
        logic saw, err;
        run(1'b0, OP_SW, 32'h4, 32'h80FF7F01, edges, saw, err);
        for (int i = 0; i < 5; i++) begin
            run(1'b0, ops[i], adrs[i], 32'hFFFF_FFFF, edges, saw, err);
            tests_run++; if (rdata1 !== exps[i] || edges != 2 || err !== 1'b0) begin tests_failed++; $display("FAIL load_%0d got rdata %h edges %0d err %b exp %h 2 0", i, rdata1, edges, err, exps[i]); end
        end
        tests_run++; if (mem1[1] !== 32'h80FF7F01) begin tests_failed++; $display("FAIL load_nowrite got %h exp 80ff7f01", mem1[1]); end
    endtask

    task automatic test_store_half();
        int   edges;
        logic saw, err;
        run(1'b0, OP_SW, 32'h0, 32'h11223344, edges, saw, err);
        req1 = 1'b1; op1 = OP_SH; addr1 = 32'h2; wdata1 = 32'h1234ABCD;
        tick();
        tests_run++; if ({sel1, we1, mdata1, maddr1} !== {4'b0011, 1'b1, 32'hABCDABCD, 32'h0}) begin tests_failed++; $display("FAIL sh_access got sel %b we %b data %h addr %h exp 0011 1 abcdabcd 0", sel1, we1, mdata1, maddr1); end
        tick();
        tests_run++; if (done1 !== 1'b1) begin tests_failed++; $display("FAIL sh_done got %b exp 1", done1); end
        req1 = 1'b0;
        tick();
        run(1'b0, OP_LW, 32'h0, 32'h0, edges, saw, err);
        tests_run++; if (rdata1 !== 32'h1122ABCD) begin tests_failed++; $display("FAIL sh_readback got %h exp 1122abcd", rdata1); end
    endtask

    task automatic test_misaligned();
        int   edges;
        logic saw, err;
        run(1'b0, OP_LW, 32'h6, 32'h0, edges, saw, err);
        tests_run++; if (edges != 1 || err !== 1'b1 || saw !== 1'b0) begin tests_failed++; $display("FAIL mis_lw got edges %0d err %b ce %b exp 1 1 0", edges, err, saw); end
        tests_run++; if (rdata1 !== 32'h1122ABCD || err1 !== 1'b0) begin tests_failed++; $display("FAIL mis_lw_hold got rdata %h err %b exp 1122abcd 0", rdata1, err1); end
        run(1'b0, OP_SH, 32'h5, 32'h0, edges, saw, err);
        tests_run++; if (edges != 1 || err !== 1'b1 || saw !== 1'b0 || mem1[1] !== 32'h80FF7F01) begin tests_failed++; $display("FAIL mis_sh got edges %0d err %b ce %b mem %h exp 1 1 0 80ff7f01", edges, err, saw, mem1[1]); end
        run(1'b0, OP_SB, 32'h3, 32'h00000077, edges, saw, err);
        tests_run++; if (edges != 2 || err !== 1'b0 || mem1[0] !== 32'h1122AB77) begin tests_failed++; $display("FAIL sb_off3 got edges %0d err %b mem %h exp 2 0 1122ab77", edges, err, mem1[0]); end
    endtask

    task automatic test_nop();
        int   edges;
        logic saw, err;
        run(1'b0, 4'hF, 32'h0, 32'h0, edges, saw, err);
        tests_run++; if (edges != 1 || err !== 1'b0 || saw !== 1'b0 || rdata1 !== 32'h1122ABCD) begin tests_failed++; $display("FAIL nop got edges %0d err %b ce %b rdata %h exp 1 0 0 1122abcd", edges, err, saw, rdata1); end
    endtask

    task automatic test_back_to_back();
        req1 = 1'b1; op1 = OP_SW; addr1 = 32'hC; wdata1 = 32'h0BADF00D;
        tick();
        tick();
        tests_run++; if (done1 !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_done got %b exp 1", done1); end
        op1 = OP_LW;
        tick();
        tests_run++; if ({done1, ce1, stall1} !== 3'b001) begin tests_failed++; $display("FAIL b2b_bubble got %b exp 001", {done1, ce1, stall1}); end
        tick();
        tests_run++; if ({ce1, we1, stall1} !== 3'b101) begin tests_failed++; $display("FAIL b2b_second_access got %b exp 101", {ce1, we1, stall1}); end
        tick();
        tests_run++; if (done1 !== 1'b1 || rdata1 !== 32'h0BADF00D) begin tests_failed++; $display("FAIL b2b_second_done got done %b rdata %h exp 1 0badf00d", done1, rdata1); end
        req1 = 1'b0;
        tick();
    endtask

    task automatic test_wait3_reset();
        int   edges;
        logic saw, err;
        req3 = 1'b1; op3 = OP_SB; addr3 = 32'h1; wdata3 = 32'h5A;
        tick();
        tests_run++; if ({ce3, we3, sel3, mdata3} !== {1'b1, 1'b1, 4'b0100, 32'h5A5A5A5A}) begin tests_failed++; $display("FAIL w3_sb_access got ce %b we %b sel %b data %h exp 1 1 0100 5a5a5a5a", ce3, we3, sel3, mdata3); end
        tick();
        rst3 = 1'b0; req3 = 1'b0;
        #1;
        tests_run++; if ({stall3, done3, err3, ce3, we3, sel3, rdata3, maddr3, mdata3} !== 105'h0) begin tests_failed++; $display("FAIL w3_async_reset got %h exp 0", {stall3, done3, err3, ce3, we3, sel3, rdata3, maddr3, mdata3}); end
        tick();
        rst3 = 1'b1;
        tick();
        run(1'b1, OP_SW, 32'h8, 32'hCAFEF00D, edges, saw, err);
        run(1'b1, OP_LW, 32'h8, 32'h0, edges, saw, err);
        tests_run++; if (edges != 4 || rdata3 !== 32'hCAFEF00D || saw !== 1'b1) begin tests_failed++; $display("FAIL w3_lw_after_reset got edges %0d rdata %h ce %b exp 4 cafef00d 1", edges, rdata3, saw); end
    endtask

    task automatic test_req_drop();
        int k;
        req3 = 1'b1; op3 = OP_SW; addr3 = 32'h10; wdata3 = 32'h13572468;
        tick();
        req3 = 1'b0; op3 = OP_NOP; wdata3 = 32'h0;
        tick();
        tests_run++; if ({ce3, we3, stall3} !== 3'b111) begin tests_failed++; $display("FAIL drop_still_access got %b exp 111", {ce3, we3, stall3}); end
        k = -1;
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (done3) begin
                k = i;
                break;
            end
        end
        tests_run++; if (k != 3) begin tests_failed++; $display("FAIL drop_done got edge %0d exp 3", k); end
        tick();
        tests_run++; if (mem3[4] !== 32'h13572468) begin tests_failed++; $display("FAIL drop_mem got %h exp 13572468", mem3[4]); end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_loads();
        test_store_half();
        test_misaligned();
        test_nop();
        test_back_to_back();
        test_wait3_reset();
        test_req_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
